dpll_loop_filter: RTL and testbench

PI loop filter for the GPS-disciplined DPLL. It sits between the PPS phase detector and the DAC SPI byte sequencer, all in the `clk_200` domain. On each PPS-qualified phase error sample it updates a saturating integrator and computes a proportional term. It then emits a clamped 16-bit offset-binary DAC code through a valid/ready handshake.

---
 rtl/dpll_pkg.sv | 25 ++
 rtl/dpll_lock_detect.sv | 52 +++++
 rtl/dpll_loop_filter.sv | 145 ++++++++++++++
 tb/tb_dpll_loop_filter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared types, widths and helpers for the DPLL loop filter
package dpll_pkg;

  localparam int ERR_W   = 16;
  localparam int INTEG_W = 32;

  localparam logic [15:0] DAC_MID_DEFAULT = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    SUM,
    CLAMP,
    SEND
  } lf_state_t;

  // Overflow shows up as disagreement between the two top bits of the 33-bit sum.
  function automatic logic signed [INTEG_W-1:0] sat32(input logic signed [INTEG_W:0] v);
    if (v[INTEG_W] != v[INTEG_W-1]) begin
      return v[INTEG_W] ? {1'b1, {(INTEG_W-1){1'b0}}} : {1'b0, {(INTEG_W-1){1'b1}}};
    end
    return v[INTEG_W-1:0];
  endfunction

endpackage

// File: rtl/dpll_lock_detect.sv
// rtl/dpll_lock_detect.sv - counts consecutive in-tolerance phase errors, flags lock
module dpll_lock_detect
  import dpll_pkg::*;
#(
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_COUNT = 8
) (
  input  logic                    clk_200,
  input  logic                    reset,
  input  logic                    upd,
  input  logic signed [ERR_W-1:0] err,
  output logic                    locked
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [ERR_W:0] TOL     = LOCK_TOL[ERR_W:0];
  localparam logic [CW-1:0]  CNT_MAX = LOCK_COUNT[CW-1:0];

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  locked_q, locked_d;
  logic signed [ERR_W:0] err_ext;
  logic [ERR_W:0]        mag;

  // One extra bit so that |-32768| is representable.
  assign err_ext = {err[ERR_W-1], err};
  assign mag     = err_ext[ERR_W] ? -err_ext : err_ext;

  always_comb begin
    cnt_d = cnt_q;
    if (upd) begin
      if (mag <= TOL) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
    locked_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_200) begin
    if (reset) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/dpll_loop_filter.sv
// rtl/dpll_loop_filter.sv - PI loop filter with anti-windup driving an offset-binary DAC code
// Lock detection is built only when DPLL_LOOP_FILTER_LOCK_DET_EN is defined.
module dpll_loop_filter
  import dpll_pkg::*;
#(
  parameter logic signed [ERR_W-1:0] KP         = 16'sd256,
  parameter logic signed [ERR_W-1:0] KI         = 16'sd16,
  parameter int                      FRAC_BITS  = 8,
  parameter logic [15:0]             DAC_MID    = DAC_MID_DEFAULT,
  parameter int                      LOCK_TOL   = 1,
  parameter int                      LOCK_COUNT = 8
) (
  input  logic                clk_200,
  input  logic                reset,
  input  logic                err_valid,
  input  logic [ERR_W-1:0]    phase_err,
  input  logic                dac_ready,
  output logic [15:0]         dac_val,
  output logic                dac_valid,
  output logic                overrun,
  output logic                locked,
  output logic [INTEG_W-1:0]  integ_out
);

  lf_state_t                 state_q, state_d;
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic signed [INTEG_W-1:0] p_q, p_d, i_q, i_d;
  logic signed [INTEG_W-1:0] integ_q, integ_d, integ_c_q, integ_c_d;
  logic signed [INTEG_W:0]   s_q, s_d;
  logic [15:0]               dac_val_q, dac_val_d;
  logic                      dac_valid_q, dac_valid_d;
  logic                      overrun_q, overrun_d;

  logic signed [INTEG_W-1:0] kp_ext, ki_ext, err_ext;
  logic signed [INTEG_W:0]   integ_sum;
  logic signed [INTEG_W+1:0] s_ext, s_shift, y;
  logic                      clamped;
  logic [15:0]               y_clamped;

  assign kp_ext  = {{(INTEG_W-ERR_W){KP[ERR_W-1]}}, KP};
  assign ki_ext  = {{(INTEG_W-ERR_W){KI[ERR_W-1]}}, KI};
  assign err_ext = {{(INTEG_W-ERR_W){err_q[ERR_W-1]}}, err_q};

  assign integ_sum = {integ_q[INTEG_W-1], integ_q} + {i_q[INTEG_W-1], i_q};
  assign s_ext     = {s_q[INTEG_W], s_q};
  assign s_shift   = s_ext >>> FRAC_BITS;
  assign y         = s_shift + $signed({18'd0, DAC_MID});
  assign clamped   = y[INTEG_W+1] | (|y[INTEG_W:16]);
  assign y_clamped = y[INTEG_W+1] ? 16'h0000 : ((|y[INTEG_W:16]) ? 16'hFFFF : y[15:0]);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    p_d         = p_q;
    i_d         = i_q;
    integ_d     = integ_q;
    integ_c_d   = integ_c_q;
    s_d         = s_q;
    dac_val_d   = dac_val_q;
    dac_valid_d = dac_valid_q;
    overrun_d   = overrun_q | (err_valid && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (err_valid) begin
          err_d   = phase_err;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = kp_ext * err_ext;
        i_d     = ki_ext * err_ext;
        state_d = SUM;
      end
      SUM: begin
        integ_c_d = sat32(integ_sum);
        s_d       = {integ_c_d[INTEG_W-1], integ_c_d} + {p_q[INTEG_W-1], p_q};
        state_d   = CLAMP;
      end
      CLAMP: begin
        dac_val_d = y_clamped;
        if (!clamped) integ_d = integ_c_q;
        state_d = SEND;
      end
      SEND: begin
        // dac_valid rises one cycle into SEND, so the code is already settled.
        if (dac_valid_q && dac_ready) begin
          dac_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          dac_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_200) begin
    if (reset) begin
      state_q     <= IDLE;
      err_q       <= '0;
      p_q         <= '0;
      i_q         <= '0;
      integ_q     <= '0;
      integ_c_q   <= '0;
      s_q         <= '0;
      dac_val_q   <= DAC_MID;
      dac_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      p_q         <= p_d;
      i_q         <= i_d;
      integ_q     <= integ_d;
      integ_c_q   <= integ_c_d;
      s_q         <= s_d;
      dac_val_q   <= dac_val_d;
      dac_valid_q <= dac_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef DPLL_LOOP_FILTER_LOCK_DET_EN
  dpll_lock_detect #(
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock_detect (
    .clk_200 (clk_200),
    .reset   (reset),
    .upd     (state_q == CLAMP),
    .err     (err_q),
    .locked  (locked)
  );
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_TOL, LOCK_COUNT};
  assign locked          = 1'b0;
`endif

  assign dac_val   = dac_val_q;
  assign dac_valid = dac_valid_q;
  assign overrun   = overrun_q;
  assign integ_out = integ_q;

endmodule

// File: tb/tb_dpll_loop_filter.sv
// tb/tb_dpll_loop_filter.sv - directed bench with a latency/arithmetic model of the PI filter
module tb_dpll_loop_filter;

  localparam longint M_KP    = 256;
  localparam longint M_KI    = 16;
  localparam longint M_SCALE = 256;
  localparam longint M_MID   = 32768;
  localparam longint M_TOL   = 1;
  localparam int     M_LOCKN = 3;

  logic        clk_200 = 1'b0;
  logic        reset;
  logic        err_valid;
  logic [15:0] phase_err;
  logic        dac_ready;
  logic [15:0] dac_val;
  logic        dac_valid;
  logic        overrun;
  logic        locked;
  logic [31:0] integ_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk_200 = ~clk_200;

  dpll_loop_filter #(
    .KP         (16'sd256),
    .KI         (16'sd16),
    .FRAC_BITS  (8),
    .DAC_MID    (16'h8000),
    .LOCK_TOL   (1),
    .LOCK_COUNT (M_LOCKN)
  ) dut (
    .clk_200   (clk_200),
    .reset     (reset),
    .err_valid (err_valid),
    .phase_err (phase_err),
    .dac_ready (dac_ready),
    .dac_val   (dac_val),
    .dac_valid (dac_valid),
    .overrun   (overrun),
    .locked    (locked),
    .integ_out (integ_out)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Model: a transaction accepted at edge N updates the code at N+3 and raises valid at N+4.
  bit     m_busy, m_valid, m_ov, m_locked, m_accept;
  int     m_age, m_lcnt;
  longint m_err, m_val, m_integ;

  task automatic model_apply();
    longint p, i, ic, s, yv;
    p  = M_KP * m_err;
    i  = M_KI * m_err;
    ic = m_integ + i;
    if (ic > 64'sd2147483647) ic = 64'sd2147483647;
    if (ic < -64'sd2147483648) ic = -64'sd2147483648;
    s  = ic + p;
    yv = floor_div(s, M_SCALE) + M_MID;
    if (yv < 0) m_val = 0;
    else if (yv > 65535) m_val = 65535;
    else begin
      m_val   = yv;
      m_integ = ic;
    end
`ifdef DPLL_LOOP_FILTER_LOCK_DET_EN
    if (m_err <= M_TOL && m_err >= -M_TOL) begin
      if (m_lcnt < M_LOCKN) m_lcnt++;
    end else begin
      m_lcnt = 0;
    end
    m_locked = (m_lcnt == M_LOCKN);
`endif
  endtask

  always @(posedge clk_200) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_ov = 0; m_locked = 0;
      m_age = 0; m_lcnt = 0; m_val = M_MID; m_integ = 0; m_err = 0;
    end else begin
      m_accept = err_valid && !m_busy;
      if (err_valid && m_busy) m_ov = 1;
      if (m_busy) begin
        if (m_valid && dac_ready) begin
          m_valid = 0;
          m_busy  = 0;
        end else begin
          m_age++;
          if (m_age == 3) model_apply();
          if (m_age == 4) m_valid = 1;
        end
      end
      if (m_accept) begin
        m_busy = 1;
        m_age  = 0;
        m_err  = longint'($signed(phase_err));
      end
    end
  end

  always @(negedge clk_200) begin
    if (chk_en) begin
      check("model_dac_valid", longint'(dac_valid), longint'(m_valid));
      check("model_dac_val", longint'(dac_val), m_val);
      check("model_integ_out", longint'($signed(integ_out)), m_integ);
      check("model_overrun", longint'(overrun), longint'(m_ov));
      check("model_locked", longint'(locked), longint'(m_locked));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk_200);
    reset = 1'b1;
    repeat (2) @(negedge clk_200);
    reset = 1'b0;
  endtask

  // Returns at the first negedge where dac_valid is high.
  task automatic sample(input logic [15:0] e);
    int lat;
    @(negedge clk_200);
    err_valid = 1'b1;
    phase_err = e;
    @(negedge clk_200);
    err_valid = 1'b0;
    lat = 0;
    while (!dac_valid && lat < 20) begin
      @(negedge clk_200);
      lat++;
    end
    check("latency", lat, 4);
  endtask

  initial begin
    reset     = 1'b1;
    err_valid = 1'b0;
    phase_err = '0;
    dac_ready = 1'b1;
    repeat (3) @(negedge clk_200);
    check("reset_dac_val", dac_val, 16'h8000);
    check("reset_dac_valid", dac_valid, 0);
    check("reset_integ", integ_out, 0);
    check("reset_locked", locked, 0);
    check("reset_overrun", overrun, 0);
    chk_en = 1'b1;
    reset  = 1'b0;

    sample(16'd4);
    check("p4_dac_val", dac_val, 16'h8004);
    check("p4_integ", longint'($signed(integ_out)), 64);
    @(negedge clk_200);
    check("p4_single_valid", dac_valid, 0);
    sample(16'd4);
    check("p4b_dac_val", dac_val, 16'h8004);
    check("p4b_integ", longint'($signed(integ_out)), 128);
    @(negedge clk_200);

    do_reset();
    sample(-16'sd9);
    check("m9_dac_val", dac_val, 16'h7FF6);
    check("m9_integ", longint'($signed(integ_out)), -144);
    @(negedge clk_200);

    do_reset();
    sample(16'h7FFF);
    check("max_dac_val", dac_val, 16'hFFFF);
    check("max_integ", longint'($signed(integ_out)), 0);
    sample(16'h8000);
    check("min_dac_val", dac_val, 16'h0000);
    check("min_integ", longint'($signed(integ_out)), 0);
    check("b2b_overrun", overrun, 0);
    @(negedge clk_200);

    do_reset();
    dac_ready = 1'b0;
    @(negedge clk_200);
    err_valid = 1'b1;
    phase_err = 16'd4;
    @(negedge clk_200);
    err_valid = 1'b0;
    @(negedge clk_200);
    err_valid = 1'b1;
    phase_err = 16'h0100;
    @(negedge clk_200);
    err_valid = 1'b0;
    for (int k = 0; k < 20 && !dac_valid; k++) @(negedge clk_200);
    check("ov_flag", overrun, 1);
    repeat (5) begin
      @(negedge clk_200);
      check("ov_hold_valid", dac_valid, 1);
      check("ov_hold_val", dac_val, 16'h8004);
    end
    dac_ready = 1'b1;
    @(negedge clk_200);
    check("ov_xfer_done", dac_valid, 0);
    check("ov_val_kept", dac_val, 16'h8004);
    check("ov_sticky", overrun, 1);
    repeat (8) @(negedge clk_200);
    do_reset();
    @(negedge clk_200);
    check("ov_cleared", overrun, 0);

    @(negedge clk_200);
    err_valid = 1'b1;
    phase_err = 16'd100;
    @(negedge clk_200);
    err_valid = 1'b0;
    @(negedge clk_200);
    reset = 1'b1;
    @(negedge clk_200);
    reset = 1'b0;
    err_valid = 1'b1;
    reset     = 1'b1;
    phase_err = 16'd50;
    @(negedge clk_200);
    reset     = 1'b0;
    err_valid = 1'b0;
    repeat (8) @(negedge clk_200);
    check("midreset_valid", dac_valid, 0);
    check("midreset_integ", integ_out, 0);
    check("midreset_val", dac_val, 16'h8000);

    do_reset();
    sample(16'd0);
    check("lock_1", locked, 0);
    sample(16'd0);
    check("lock_2", locked, 0);
    sample(16'd0);
`ifdef DPLL_LOOP_FILTER_LOCK_DET_EN
    check("lock_3", locked, 1);
`else
    check("lock_3", locked, 0);
`endif
    sample(16'd5);
    check("lock_lost", locked, 0);
    @(negedge clk_200);
    repeat (4) @(negedge clk_200);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
